nan_frame_writer: RTL and testbench

- Capture stage directly upstream of the Bayer decoder.
- Takes the NanEye raw 8-bit pixel stream (valid/SOF/EOL-qualified), computes each pixel's linear address and writes it into the raw-frame RAM.
- After a complete ROW x COL frame it pulses dec_start to the decoder. It then blocks new frames until the decoder reports dec_done, so the frame RAM is never overwritten mid-decode.

---
 rtl/nan_pkg.sv | 15 +
 rtl/nan_frame_writer_if.sv | 24 ++
 rtl/nan_frame_writer.sv | 160 ++++++++++++++++
 tb/tb_nan_frame_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nan_pkg.sv
// Shared constants and state encoding for the NanEye capture/decode path.
package nan_pkg;

    localparam int unsigned NAN_ROW    = 250;
    localparam int unsigned NAN_COL    = 250;
    localparam int unsigned NAN_ADDR_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StStart,
        StWaitDec
    } nan_wr_state_e;

endpackage

// File: rtl/nan_frame_writer_if.sv
// Pixel-stream input and frame-RAM write bus of the NanEye frame writer.
interface nan_frame_writer_if #(
    parameter int unsigned ADDR_W = nan_pkg::NAN_ADDR_W
);

    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              pix_sof;
    logic              pix_eol;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output pix_valid, pix_data, pix_sof, pix_eol,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, pix_eol,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/nan_frame_writer.sv
// Writes the raw NanEye pixel stream into the frame RAM and hands complete
// frames to the Bayer decoder, holding off new frames until it is done.
module nan_frame_writer
    import nan_pkg::*;
#(
    parameter int unsigned ROW    = NAN_ROW,
    parameter int unsigned COL    = NAN_COL,
    parameter int unsigned ADDR_W = NAN_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    nan_frame_writer_if.slave  bus,
    input  logic               dec_done,
    input  logic               err_clr,
    output logic               dec_start,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         drop_cnt,
    output logic               err_line,
    output logic               err_frame
);

    localparam int unsigned XW = $clog2(COL + 1);
    localparam int unsigned YW = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [XW-1:0]     ColX  = XW'(COL);
    localparam logic [XW:0]       ColX1 = (XW + 1)'(COL);
    localparam logic [XW:0]       OneX1 = (XW + 1)'(1);
    localparam logic [YW-1:0]     LastY = YW'(ROW - 1);
    localparam logic [ADDR_W-1:0] ColA  = ADDR_W'(COL);

    if (longint'(ROW) * longint'(COL) > (longint'(1) << ADDR_W)) begin : g_size_check
        $error("nan_frame_writer: ROW*COL does not fit in ADDR_W address bits");
    end

    nan_wr_state_e     state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              err_line_q, err_line_d;
    logic              err_frame_q, err_frame_d;

    logic              sof_hit;
    logic              accept;
    logic [XW-1:0]     x_cur;
    logic [YW-1:0]     y_cur;
    logic [ADDR_W-1:0] rb_cur;
    logic [XW:0]       x_inc;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rb_d        = rb_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        // Clear first so that a same-cycle error event below wins.
        err_line_d  = err_line_q & ~err_clr;
        err_frame_d = err_frame_q & ~err_clr;
        sof_hit     = bus.pix_valid & bus.pix_sof;
        accept      = 1'b0;
        x_cur       = x_q;
        y_cur       = y_q;
        rb_cur      = rb_q;
        x_inc       = '0;

        unique case (state_q)
            StIdle: accept = sof_hit;
            StCapture: begin
                accept = bus.pix_valid;
                if (sof_hit) err_frame_d = 1'b1;
            end
            StStart: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StWaitDec;
            end
            StWaitDec: begin
                if (sof_hit && drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
                if (dec_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            // An SOF pixel is pixel 0 of line 0, whatever came before it.
            if (bus.pix_sof) begin
                x_cur   = '0;
                y_cur   = '0;
                rb_cur  = '0;
                state_d = StCapture;
            end
            if (x_cur < ColX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = rb_cur + ADDR_W'(x_cur);
                wr_data_d = bus.pix_data;
            end else begin
                err_line_d = 1'b1;
            end
            x_inc = {1'b0, x_cur} + OneX1;
            if (bus.pix_eol) begin
                if (x_inc != ColX1) err_line_d = 1'b1;
                x_d  = '0;
                y_d  = y_cur + YW'(1);
                rb_d = rb_cur + ColA;
                if (y_cur == LastY) state_d = StStart;
            end else begin
                x_d  = (x_cur == ColX) ? x_cur : x_inc[XW-1:0];
                y_d  = y_cur;
                rb_d = rb_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            rb_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rb_q        <= rb_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign dec_start   = (state_q == StStart);
    assign busy        = (state_q != StIdle);
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_nan_frame_writer.sv
// Scoreboard bench for nan_frame_writer: expected RAM writes are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_nan_frame_writer;

    localparam int ROW = 8;
    localparam int COL = 250;
    localparam int AW  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dec_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        dec_start;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic        err_line;
    logic        err_frame;

    nan_frame_writer_if #(.ADDR_W(AW)) bus ();

    nan_frame_writer #(
        .ROW    (ROW),
        .COL    (COL),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dec_done  (dec_done),
        .err_clr   (err_clr),
        .dec_start (dec_start),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .err_line  (err_line),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          start;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                chk("dec_start_on_write", 32'(dec_start), 32'(e.start));
            end
        end else begin
            chk("dec_start_no_write", 32'(dec_start), 32'd0);
        end
    end

    task automatic pix(input logic [7:0] d, input logic sof, input logic eol);
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        bus.pix_eol   = eol;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_eol   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pixels first..n-1 of line y; data (x+y)&255, expected address y*COL+x.
    task automatic line(input int y, input int first, input int n, input bit sof,
                        input bit eol_end, input bit last, input bit expect_wr);
        for (int i = first; i < n; i++) begin
            logic [7:0] d;
            bit         e;
            d = 8'(i + y);
            e = eol_end && (i == n - 1);
            if (expect_wr && i < COL)
                exp_q.push_back(exp_t'{addr: AW'(y * COL + i), data: d, start: last && e});
            pix(d, sof && (i == first), e);
        end
    endtask

    task automatic frame(input bit expect_wr);
        for (int y = 0; y < ROW; y++) line(y, 0, COL, y == 0, 1'b1, y == ROW - 1, expect_wr);
    endtask

    task automatic pulse_done();
        dec_done = 1'b1;
        @(posedge clk);
        #1;
        dec_done = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
                 n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stimulus
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.pix_sof   = 1'b0;
        bus.pix_eol   = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dec_start", 32'(dec_start), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset_err_line", 32'(err_line), 32'd0);
        chk("reset_err_frame", 32'(err_frame), 32'd0);

        // Non-SOF pixels in IDLE are ignored.
        line(0, 0, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clean frame, continuous valid.
        frame(1'b1);
        idle(3);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_err_line", 32'(err_line), 32'd0);
        chk("t1_err_frame", 32'(err_frame), 32'd0);
        chk("t1_busy_wait_dec", 32'(busy), 32'd1);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        pulse_done();
        chk("t1_busy_after_done", 32'(busy), 32'd0);

        // Line 3 short (200 pixels); line 4 restarts at address 1000.
        for (int y = 0; y < ROW; y++)
            line(y, 0, (y == 3) ? 200 : COL, y == 0, 1'b1, y == ROW - 1, 1'b1);
        idle(3);
        chk("t2_err_line", 32'(err_line), 32'd1);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
        pulse_done();
        pulse_clr();
        chk("t2_err_line_cleared", 32'(err_line), 32'd0);

        // Line 0 long (260 pixels); only 250 writes, line 1 at address 250.
        for (int y = 0; y < ROW; y++)
            line(y, 0, (y == 0) ? 260 : COL, y == 0, 1'b1, y == ROW - 1, 1'b1);
        idle(3);
        chk("t3_err_line", 32'(err_line), 32'd1);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        pulse_done();
        pulse_clr();
        chk("t3_err_line_cleared", 32'(err_line), 32'd0);

        // SOF at line 5 pixel 17 restarts the frame at address 0.
        for (int y = 0; y < 5; y++) line(y, 0, COL, y == 0, 1'b1, 1'b0, 1'b1);
        line(5, 0, 17, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b1);
        idle(3);
        chk("t4_err_frame", 32'(err_frame), 32'd1);
        chk("t4_err_line", 32'(err_line), 32'd0);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);
        pulse_clr();
        chk("t4_err_frame_cleared", 32'(err_frame), 32'd0);

        // Still in WAIT_DEC: whole frames are dropped, not written.
        frame(1'b0);
        chk("t5_drop_cnt_1", 32'(drop_cnt), 32'd1);
        chk("t5_busy_wait_dec", 32'(busy), 32'd1);
        dec_done = 1'b1;
        pix(8'h00, 1'b1, 1'b0);
        dec_done = 1'b0;
        line(0, 1, COL, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int y = 1; y < ROW; y++) line(y, 0, COL, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t5_drop_cnt_2", 32'(drop_cnt), 32'd2);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset at pixel 1000 of a frame; remainder of that frame is ignored.
        for (int y = 0; y < 4; y++) line(y, 0, COL, y == 0, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        pix(8'd4, 1'b0, 1'b0);
        reset = 1'b0;
        chk("t6_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6_err_line", 32'(err_line), 32'd0);
        line(4, 1, COL, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int y = 5; y < ROW; y++) line(y, 0, COL, 1'b0, 1'b1, y == ROW - 1, 1'b0);
        idle(3);
        chk("t6_no_start_frame_cnt", 32'(frame_cnt), 32'd0);
        frame(1'b1);
        idle(3);
        chk("t6_fresh_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
